// File: rtl/vai_tx_req_buffer.sv
// vai_tx_req_buffer: PE-to-mux Tx request FIFO with registered output and early almost-full
//   pClk/SoftReset_n     : clock, async active-low reset
//   in_valid/in_data     : PE request (no ready; dropped when full)
//   in_almfull           : back-pressure to PE, count >= ALMFULL_THRESH
//   out_valid/out_data   : registered request toward the mux
//   out_almfull          : mux-side almost-full, stalls draining
//   occupancy            : current entry count
//   overflow_err         : sticky drop flag
//   issued_cnt           : requests issued, wraps
module vai_tx_req_buffer #(
  parameter int DATA_W         = 600,
  parameter int DEPTH          = 32,
  parameter int ALMFULL_THRESH = 24
) (
  input  logic                       pClk,
  input  logic                       SoftReset_n,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_almfull,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_almfull,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       overflow_err,
  output logic [31:0]                issued_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] THR  = CW'(ALMFULL_THRESH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [31:0]       issued_cnt_q, issued_cnt_d;
  logic              pop, push;
  always_comb begin
    pop          = (count_q != '0) && !out_almfull;
    // a full FIFO still accepts when it frees a slot on the same edge
    push         = in_valid && ((count_q < FULL) || pop);
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    ovf_d        = ovf_q | (in_valid && !push);
    out_valid_d  = pop;
    out_data_d   = pop ? mem_q[rd_ptr_q] : out_data_q;
    issued_cnt_d = issued_cnt_q + 32'(pop);
  end
  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      issued_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end
  // storage is deliberately left unreset; only pointers define validity
  always_ff @(posedge pClk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end
  assign in_almfull   = count_q >= THR;
  assign occupancy    = count_q;
  assign overflow_err = ovf_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign issued_cnt   = issued_cnt_q;
endmodule

// File: tb/tb_vai_tx_req_buffer.sv
// tb_vai_tx_req_buffer: randomized and directed check of vai_tx_req_buffer against a queue model
module tb_vai_tx_req_buffer;
  localparam int DATA_W = 600;
  localparam int DEPTH  = 32;
  localparam int THR    = 24;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_almfull = 1'b0;
  logic              in_almfull, out_valid, overflow_err;
  logic [DATA_W-1:0] out_data;
  logic [$clog2(DEPTH):0] occupancy;
  logic [31:0]       issued_cnt;
  int                passed = 0, total = 0;
  logic [DATA_W-1:0] mq[$];
  logic              m_oval = 1'b0, m_ovf = 1'b0;
  logic [DATA_W-1:0] m_odata = '0;
  logic [31:0]       m_iss = '0;
  vai_tx_req_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ALMFULL_THRESH(THR)) dut (
    .pClk(clk), .SoftReset_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_almfull(in_almfull), .out_valid(out_valid), .out_data(out_data),
    .out_almfull(out_almfull), .occupancy(occupancy), .overflow_err(overflow_err),
    .issued_cnt(issued_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
    else passed++;
  endtask
  function automatic logic [DATA_W-1:0] rnd();
    logic [DATA_W-1:0] r = '0;
    for (int i = 0; i < (DATA_W + 31) / 32; i++) r = {r[DATA_W-33:0], 32'($urandom)};
    return r;
  endfunction
  task automatic model_reset();
    mq.delete();
    m_oval = 1'b0;
    m_odata = '0;
    m_iss = '0;
    m_ovf = 1'b0;
  endtask
  // one clock edge of the model: decide from pre-edge state, then apply after the edge
  task automatic tick();
    bit pop, push, v;
    logic [DATA_W-1:0] d;
    pop  = mq.size() != 0 && !out_almfull;
    push = in_valid && (mq.size() < DEPTH || pop);
    v = in_valid;
    d = in_data;
    @(posedge clk);
    m_oval = pop;
    if (pop) begin
      m_odata = mq.pop_front();
      m_iss++;
    end
    if (push) mq.push_back(d);
    else if (v) m_ovf = 1'b1;
    #1;
  endtask
  always @(negedge clk) begin
    chk("occupancy", DATA_W'(occupancy), DATA_W'(mq.size()));
    chk("in_almfull", DATA_W'(in_almfull), DATA_W'(mq.size() >= THR));
    chk("out_valid", DATA_W'(out_valid), DATA_W'(m_oval));
    if (m_oval) chk("out_data", out_data, m_odata);
    chk("overflow_err", DATA_W'(overflow_err), DATA_W'(m_ovf));
    chk("issued_cnt", DATA_W'(issued_cnt), DATA_W'(m_iss));
  end
  initial begin
    int n, mx;
    logic [DATA_W-1:0] b;
    #12;
    chk("rst out_valid", DATA_W'(out_valid), '0);
    chk("rst out_data", out_data, '0);
    chk("rst occupancy", DATA_W'(occupancy), '0);
    chk("rst issued", DATA_W'(issued_cnt), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = DATA_W'(1);
    tick();
    in_valid = 1'b0;
    chk("single occ1", DATA_W'(occupancy), DATA_W'(1));
    chk("single noval", DATA_W'(out_valid), '0);
    tick();
    chk("single val", DATA_W'(out_valid), DATA_W'(1));
    chk("single data", out_data, DATA_W'(1));
    chk("single occ0", DATA_W'(occupancy), '0);
    chk("single iss", DATA_W'(issued_cnt), DATA_W'(1));
    n = 0; mx = 0;
    for (int i = 0; i < 104; i++) begin
      in_valid = i < 100;
      in_data = DATA_W'(i + 100);
      tick();
      if (out_valid) n++;
      if (int'(occupancy) > mx) mx = int'(occupancy);
      if (in_almfull) mx = 99;
    end
    chk("stream count", DATA_W'(n), DATA_W'(100));
    chk("stream maxocc", DATA_W'(mx <= 2), DATA_W'(1));
    out_almfull = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = rnd();
      tick();
      chk("fill almfull", DATA_W'(in_almfull), DATA_W'(i + 1 >= THR));
      if (out_valid) chk("fill noval", DATA_W'(out_valid), '0);
    end
    chk("fill occ", DATA_W'(occupancy), DATA_W'(DEPTH));
    out_almfull = 1'b0; in_data = rnd();
    tick();
    chk("full pushpop occ", DATA_W'(occupancy), DATA_W'(DEPTH));
    chk("full pushpop ovf", DATA_W'(overflow_err), '0);
    out_almfull = 1'b1; in_data = rnd();
    tick();
    chk("drop ovf", DATA_W'(overflow_err), DATA_W'(1));
    chk("drop occ", DATA_W'(occupancy), DATA_W'(DEPTH));
    in_valid = 1'b0; out_almfull = 1'b0; n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) n++;
    end
    chk("drain count", DATA_W'(n), DATA_W'(DEPTH));
    out_almfull = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = rnd();
      tick();
    end
    in_valid = 1'b0; out_almfull = 1'b0;
    tick(); tick();
    chk("pre-rst occ", DATA_W'(occupancy), DATA_W'(10));
    chk("pre-rst val", DATA_W'(out_valid), DATA_W'(1));
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async val", DATA_W'(out_valid), '0);
    chk("async data", out_data, '0);
    chk("async occ", DATA_W'(occupancy), '0);
    chk("async almfull", DATA_W'(in_almfull), '0);
    chk("async ovf", DATA_W'(overflow_err), '0);
    chk("async iss", DATA_W'(issued_cnt), '0);
    #3 rst_n = 1'b1;
    tick();
    b = rnd();
    in_valid = 1'b1; in_data = b;
    tick();
    in_valid = 1'b0;
    tick();
    chk("post-rst val", DATA_W'(out_valid), DATA_W'(1));
    chk("post-rst data", out_data, b);
    chk("post-rst occ", DATA_W'(occupancy), '0);
    force dut.issued_cnt_q = 32'hFFFF_FFFE;
    m_iss = 32'hFFFF_FFFE;
    #1 release dut.issued_cnt_q;
    for (int i = 0; i < 6; i++) begin
      in_valid = i < 3; in_data = rnd();
      tick();
    end
    chk("wrap iss", DATA_W'(issued_cnt), DATA_W'(1));
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 400; i++) begin
        in_valid = $urandom_range(99) < 75;
        in_data = rnd();
        out_almfull = $urandom_range(99) < s * 15;
        tick();
      end
    end
    in_valid = 1'b0; out_almfull = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("final occ", DATA_W'(occupancy), '0);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
